cpu_check_ext: RTL
==================

// Module: cpu_check_ext
// PURPOSE
//  Byte-serial recogniser for CPU trace records, one char per clk: "^<time>@<pc>: $<grf> <= <data>#" (register) or
//  "^<time>@<pc>: *<addr> <= <data>#" (memory). Parametrised successor of the basic format checker: adds semantic
//  checks on pc/addr/grf values, an error code and a saturating count of good records. Sits on the trace-monitor path.
// PARAMETERS
//  TIME_DIGITS  4         max decimal digits in time field (min 1)
//  GRF_DIGITS   4         max decimal digits in grf field (min 1)
//  HEX_DIGITS   8         exact hex digit count of pc/addr/data
//  PC_LO        32'h3000  lowest legal pc (inclusive)
//  PC_HI        32'h6ffc  highest legal pc (inclusive)
//  ADDR_HI      32'h2ffc  highest legal memory addr (inclusive, low bound 0)
//  CNT_W        16        width of good-record counter
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  char         in   8      ASCII input, sampled every rising edge
//  format_type  out  2      00 none, 01 register record, 10 memory record
//  error_code   out  4      [0] pc bad, [1] addr bad, [2] grf>31, [3] reserved 0; all 0 when format_type==00
//  rec_cnt      out  CNT_W  count of records ended with format_type!=00 and error_code==0, saturating
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE, all accumulators/counters 0; format_type=00, error_code=0, rec_cnt=0.
//  - Outputs are decoded from registered state: format_type/error_code valid exactly the cycle after '#' is sampled
//    (state HASH), held one cycle only. rec_cnt increments on the edge that leaves HASH.
//  - States: IDLE, CARET, TIME, AT, PC, COLON, DOLLAR, STAR, GRF, ADDR, SP, LT, EQ, DATA, HASH.
//  - Transitions: IDLE-'^'->CARET; CARET-digit->TIME; TIME-digit (count<=TIME_DIGITS)->TIME, '@'->AT;
//    AT-hex->PC; PC-hex (count<=HEX_DIGITS)->PC, ':' with count==HEX_DIGITS->COLON; COLON-' '->COLON,'$'->DOLLAR,
//    '*'->STAR; DOLLAR-digit->GRF; STAR-hex->ADDR; GRF-digit (count<=GRF_DIGITS)->GRF, ' '->SP, '<'->LT;
//    ADDR-hex->ADDR, ' '/'<' only with count==HEX_DIGITS ->SP/LT; SP-' '->SP,'<'->LT; LT-'='->EQ;
//    EQ-' '->EQ, hex->DATA; DATA-hex->DATA, '#' with count==HEX_DIGITS->HASH.
//  - Any '^' in any non-IDLE state (incl. HASH) -> CARET with counters cleared (restart). Any other char not listed,
//    or digit-count overflow, -> IDLE. HASH followed by anything but '^' -> IDLE.
//  - Hex digits: '0'-'9','a'-'f' only (see CONFIGURATION). Digit counters saturate, never wrap.
//  - pc_acc/addr_acc: 32-bit, acc<=(acc<<4)|nibble, cleared on entering field. grf_acc: 14-bit, acc*10+d.
//  - Checks at HASH: pc bad if pc[1:0]!=0 or pc<PC_LO or pc>PC_HI; addr bad (memory only) if addr[1:0]!=0 or
//    addr>ADDR_HI; grf bad (register only) if grf_acc>31. Unused-kind bits forced 0.
//  - rec_cnt at 2^CNT_W-1 stays there. Reset mid-record returns to IDLE immediately; partial record discarded.
// CONFIGURATION
//  CPU_CHECK_UPPER_HEX_EN defined: 'A'-'F' also accepted as hex digits (value 10-15) in pc/addr/data.
//  Undefined: 'A'-'F' is an illegal char -> IDLE (or CARET if '^').
// STRUCTURE
//  Package cpu_check_pkg: state encoding (4-bit localparams), ASCII char constants, error-bit index constants.
//  Sub-module cpu_check_char_class: combinational decode char -> {is_dec, is_hex, nibble}; honours the macro.
//  Top: FSM, field counters, accumulators, checks, counter.
// TESTING
//  1 "^10@00003000: $5 <= 0000abcd#" -> cycle after '#': format_type=01, error_code=0, then rec_cnt 0->1.
//  2 "^7@00003002: *00000010 <= 12345678#" -> format_type=10, error_code=4'b0001, rec_cnt unchanged.
//  3 "^1@00003004: $32<=00000000#" -> format_type=01, error_code=4'b0100; "^12345@..." -> IDLE, format_type=00.
//  4 "^1@0000300: $1 <= 00000000#" (7-digit pc) and 9-digit data -> format_type stays 00 throughout.
//  5 "^1@0000^2@00003000: *00000ffc <= 0000000A#" -> restart on '^'; 10 with macro, 00 without.
//  6 reset low mid-record then complete tail -> no format_type; rec_cnt forced to 2^CNT_W-1 stays saturated.

Source files
------------

// File: rtl/cpu_check_pkg.sv
// Shared definitions for the CPU trace-record checker: FSM states,
// ASCII delimiters, error-bit positions and the field digit-counter width.
package cpu_check_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_DOLLAR, S_STAR,
    S_GRF, S_ADDR, S_SP, S_LT, S_EQ, S_DATA, S_HASH
  } state_e;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;

  localparam int unsigned ERR_PC   = 0;
  localparam int unsigned ERR_ADDR = 1;
  localparam int unsigned ERR_GRF  = 2;
  localparam int unsigned ERR_RSV  = 3;

  // Field digit counter width; counters saturate at all-ones.
  localparam int unsigned DCNT_W = 8;

endpackage

// File: rtl/cpu_check_char_class.sv
// Combinational character classifier: decimal digit, hex digit and nibble value.
// CPU_CHECK_UPPER_HEX_EN: when defined, 'A'-'F' are also hex digits.
module cpu_check_char_class (
  input  logic [7:0] ch_i,
  output logic       is_dec_o,
  output logic       is_hex_o,
  output logic [3:0] nibble_o
);

  // Decode one ASCII character into digit class and value
  always_comb begin
    is_dec_o = 1'b0;
    is_hex_o = 1'b0;
    nibble_o = '0;
    if (ch_i >= 8'h30 && ch_i <= 8'h39) begin
      is_dec_o = 1'b1;
      is_hex_o = 1'b1;
      nibble_o = ch_i[3:0];
    end else if (ch_i >= 8'h61 && ch_i <= 8'h66) begin
      is_hex_o = 1'b1;
      nibble_o = 4'(ch_i[3:0] + 4'd9);
`ifdef CPU_CHECK_UPPER_HEX_EN
    end else if (ch_i >= 8'h41 && ch_i <= 8'h46) begin
      is_hex_o = 1'b1;
      nibble_o = 4'(ch_i[3:0] + 4'd9);
`endif
    end
  end

endmodule

// File: rtl/cpu_check_ext.sv
// Byte-serial recogniser for CPU trace records with pc/addr/grf semantic
// checks and a saturating count of good records.
// CPU_CHECK_UPPER_HEX_EN: when defined, upper-case hex is accepted in pc/addr/data.
module cpu_check_ext
  import cpu_check_pkg::*;
#(
  parameter int unsigned TIME_DIGITS = 4,
  parameter int unsigned GRF_DIGITS  = 4,
  parameter int unsigned HEX_DIGITS  = 8,
  parameter logic [31:0] PC_LO       = 32'h3000,
  parameter logic [31:0] PC_HI       = 32'h6ffc,
  parameter logic [31:0] ADDR_HI     = 32'h2ffc,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  output logic [1:0]       format_type,
  output logic [3:0]       error_code,
  output logic [CNT_W-1:0] rec_cnt
);

  localparam logic [DCNT_W-1:0] TIME_N = DCNT_W'(TIME_DIGITS);
  localparam logic [DCNT_W-1:0] GRF_N  = DCNT_W'(GRF_DIGITS);
  localparam logic [DCNT_W-1:0] HEX_N  = DCNT_W'(HEX_DIGITS);

  state_e            state_q, state_d;
  logic [DCNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]       pc_q, pc_d, addr_q, addr_d;
  logic [13:0]       grf_q, grf_d;
  logic              mem_q, mem_d;
  logic [CNT_W-1:0]  rec_cnt_q, rec_cnt_d;

  logic       is_dec, is_hex;
  logic [3:0] nib;
  logic       in_hash, pc_bad, addr_bad, grf_bad;

  cpu_check_char_class u_class (
    .ch_i     (char),
    .is_dec_o (is_dec),
    .is_hex_o (is_hex),
    .nibble_o (nib)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // State register, field counter, accumulators and good-record counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pc_q      <= '0;
      addr_q    <= '0;
      grf_q     <= '0;
      mem_q     <= 1'b0;
      rec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      grf_q     <= grf_d;
      mem_q     <= mem_d;
      rec_cnt_q <= rec_cnt_d;
    end
  end

  // Next state: '^' restarts from anywhere; anything unexpected falls to IDLE
  always_comb begin
    state_d = S_IDLE;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    grf_d   = grf_q;
    mem_d   = mem_q;
    if (char == CH_CARET) begin
      state_d = S_CARET;
      cnt_d   = '0;
      pc_d    = '0;
      addr_d  = '0;
      grf_d   = '0;
      mem_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_CARET: if (is_dec) begin state_d = S_TIME; cnt_d = DCNT_W'(1); end
        S_TIME: begin
          if (is_dec && cnt_q < TIME_N) begin state_d = S_TIME; cnt_d = cnt_inc; end
          else if (char == CH_AT)       state_d = S_AT;
        end
        S_AT: if (is_hex) begin state_d = S_PC; cnt_d = DCNT_W'(1); pc_d = {28'd0, nib}; end
        S_PC: begin
          if (is_hex && cnt_q < HEX_N) begin
            state_d = S_PC;
            cnt_d   = cnt_inc;
            pc_d    = {pc_q[27:0], nib};
          end else if (char == CH_COLON && cnt_q == HEX_N) state_d = S_COLON;
        end
        S_COLON: begin
          if (char == CH_SPACE)       state_d = S_COLON;
          else if (char == CH_DOLLAR) begin state_d = S_DOLLAR; mem_d = 1'b0; end
          else if (char == CH_STAR)   begin state_d = S_STAR;   mem_d = 1'b1; end
        end
        S_DOLLAR: if (is_dec) begin state_d = S_GRF; cnt_d = DCNT_W'(1); grf_d = {10'd0, nib}; end
        S_STAR: if (is_hex) begin state_d = S_ADDR; cnt_d = DCNT_W'(1); addr_d = {28'd0, nib}; end
        S_GRF: begin
          if (is_dec && cnt_q < GRF_N) begin
            state_d = S_GRF;
            cnt_d   = cnt_inc;
            grf_d   = 14'(grf_q * 14'd10 + {10'd0, nib});
          end else if (char == CH_SPACE) state_d = S_SP;
          else if (char == CH_LT)        state_d = S_LT;
        end
        S_ADDR: begin
          if (is_hex && cnt_q < HEX_N) begin
            state_d = S_ADDR;
            cnt_d   = cnt_inc;
            addr_d  = {addr_q[27:0], nib};
          end else if (cnt_q == HEX_N && char == CH_SPACE) state_d = S_SP;
          else if (cnt_q == HEX_N && char == CH_LT)        state_d = S_LT;
        end
        S_SP: begin
          if (char == CH_SPACE)   state_d = S_SP;
          else if (char == CH_LT) state_d = S_LT;
        end
        S_LT: if (char == CH_EQ) state_d = S_EQ;
        S_EQ: begin
          if (char == CH_SPACE) state_d = S_EQ;
          else if (is_hex)      begin state_d = S_DATA; cnt_d = DCNT_W'(1); end
        end
        S_DATA: begin
          if (is_hex && cnt_q < HEX_N) begin state_d = S_DATA; cnt_d = cnt_inc; end
          else if (char == CH_HASH && cnt_q == HEX_N) state_d = S_HASH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Record result decoded from registered state; good records bump the counter
  always_comb begin
    in_hash   = (state_q == S_HASH);
    pc_bad    = (pc_q[1:0] != 2'b00) || (pc_q < PC_LO) || (pc_q > PC_HI);
    addr_bad  = mem_q && ((addr_q[1:0] != 2'b00) || (addr_q > ADDR_HI));
    grf_bad   = !mem_q && (grf_q > 14'd31);
    format_type = '0;
    error_code  = '0;
    if (in_hash) begin
      format_type          = mem_q ? 2'b10 : 2'b01;
      error_code[ERR_PC]   = pc_bad;
      error_code[ERR_ADDR] = addr_bad;
      error_code[ERR_GRF]  = grf_bad;
      error_code[ERR_RSV]  = 1'b0;
    end
    rec_cnt_d = rec_cnt_q;
    if (in_hash && error_code == '0 && rec_cnt_q != '1) rec_cnt_d = rec_cnt_q + 1'b1;
  end

  assign rec_cnt = rec_cnt_q;

endmodule
